// File: rtl/bomb_sched.sv
// Two-player bomb placement scheduler: per-player IDLE/ARMED/COOL FSM, accept checks, same-cell arbitration.
// Optional feature macro BOMB_RR_EN: round-robin tie arbitration (default: player A wins ties).
module bomb_sched #(
    parameter int COOLDOWN_TICKS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bombTick,
    input  logic         btnA,
    input  logic         btnB,
    input  logic [3:0]   playerAx,
    input  logic [3:0]   playerAy,
    input  logic [3:0]   playerBx,
    input  logic [3:0]   playerBy,
    input  logic [99:0]  i_curBombMap_0,
    input  logic [99:0]  i_curBombMap_1,
    input  logic [1:0]   game_state,
    output logic [3:0]   bombA_x,
    output logic [3:0]   bombA_y,
    output logic [3:0]   bombB_x,
    output logic [3:0]   bombB_y,
    output logic         bombA_v,
    output logic         bombB_v,
    output logic         rejA,
    output logic         rejB,
    output logic         busyA,
    output logic         busyB
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    localparam logic [2:0] CD = 3'(COOLDOWN_TICKS);

    state_t      stateA_q, stateA_d, stateB_q, stateB_d;
    logic [2:0]  cntA_q, cntA_d, cntB_q, cntB_d;
    logic [3:0]  bombA_x_q, bombA_x_d, bombA_y_q, bombA_y_d;
    logic [3:0]  bombB_x_q, bombB_x_d, bombB_y_q, bombB_y_d;
    logic        bombA_v_q, bombA_v_d, bombB_v_q, bombB_v_d;
    logic        rejA_q, rejA_d, rejB_q, rejB_d;

    logic        playing;
    logic        same_cell;
    logic        a_base, b_base;
    logic        tie;
    logic        rr_ptr;
    logic        acceptA, acceptB;

    // In-bounds and both map bits clear at index 10*x+y.
    function automatic logic cell_free(
        input logic [3:0]  x,
        input logic [3:0]  y,
        input logic [99:0] m0,
        input logic [99:0] m1
    );
        logic [6:0] idx;
        cell_free = 1'b0;
        idx       = 7'd0;
        if (x <= 4'd9 && y <= 4'd9) begin
            idx       = {3'b000, x} * 7'd10 + {3'b000, y};
            cell_free = ~(m0[idx] | m1[idx]);
        end
    endfunction

    always_comb begin
        playing   = (game_state == 2'd0);
        same_cell = (playerAx == playerBx) && (playerAy == playerBy);
        a_base    = playing
                    && cell_free(playerAx, playerAy, i_curBombMap_0, i_curBombMap_1)
                    && !(stateB_q == S_ARMED && bombB_x_q == playerAx && bombB_y_q == playerAy);
        b_base    = playing
                    && cell_free(playerBx, playerBy, i_curBombMap_0, i_curBombMap_1)
                    && !(stateA_q == S_ARMED && bombA_x_q == playerBx && bombA_y_q == playerBy);
        tie       = btnA && btnB && (stateA_q == S_IDLE) && (stateB_q == S_IDLE)
                    && same_cell && a_base && b_base;
        acceptA   = btnA && (stateA_q == S_IDLE) && a_base && (!tie || !rr_ptr);
        acceptB   = btnB && (stateB_q == S_IDLE) && b_base && (!tie ||  rr_ptr);
    end

`ifdef BOMB_RR_EN
    logic rr_q, rr_d;

    // Pointer names the tie winner (0 = A); it hands priority to the loser after each tie.
    always_comb begin
        rr_d = rr_q;
        if (tie) begin
            rr_d = ~rr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign rr_ptr = rr_q;
`else
    assign rr_ptr = 1'b0;
`endif

    // Player A next state.
    always_comb begin
        stateA_d  = stateA_q;
        cntA_d    = cntA_q;
        bombA_x_d = bombA_x_q;
        bombA_y_d = bombA_y_q;
        bombA_v_d = bombA_v_q;
        rejA_d    = 1'b0;
        if (!playing) begin
            stateA_d  = S_IDLE;
            cntA_d    = 3'd0;
            bombA_v_d = 1'b0;
        end else begin
            case (stateA_q)
                S_IDLE: begin
                    if (acceptA) begin
                        stateA_d  = S_ARMED;
                        bombA_x_d = playerAx;
                        bombA_y_d = playerAy;
                        bombA_v_d = 1'b1;
                    end else if (btnA) begin
                        rejA_d = 1'b1;
                    end
                end
                S_ARMED: begin
                    rejA_d = btnA;
                    if (bombTick) begin
                        bombA_v_d = 1'b0;
                        if (CD == 3'd0) begin
                            stateA_d = S_IDLE;
                            cntA_d   = 3'd0;
                        end else begin
                            stateA_d = S_COOL;
                            cntA_d   = CD;
                        end
                    end
                end
                S_COOL: begin
                    rejA_d = btnA;
                    if (bombTick) begin
                        if (cntA_q <= 3'd1) begin
                            stateA_d = S_IDLE;
                            cntA_d   = 3'd0;
                        end else begin
                            cntA_d = cntA_q - 3'd1;
                        end
                    end
                end
                default: begin
                    stateA_d  = S_IDLE;
                    cntA_d    = 3'd0;
                    bombA_v_d = 1'b0;
                end
            endcase
        end
    end

    // Player B next state, mirror of A.
    always_comb begin
        stateB_d  = stateB_q;
        cntB_d    = cntB_q;
        bombB_x_d = bombB_x_q;
        bombB_y_d = bombB_y_q;
        bombB_v_d = bombB_v_q;
        rejB_d    = 1'b0;
        if (!playing) begin
            stateB_d  = S_IDLE;
            cntB_d    = 3'd0;
            bombB_v_d = 1'b0;
        end else begin
            case (stateB_q)
                S_IDLE: begin
                    if (acceptB) begin
                        stateB_d  = S_ARMED;
                        bombB_x_d = playerBx;
                        bombB_y_d = playerBy;
                        bombB_v_d = 1'b1;
                    end else if (btnB) begin
                        rejB_d = 1'b1;
                    end
                end
                S_ARMED: begin
                    rejB_d = btnB;
                    if (bombTick) begin
                        bombB_v_d = 1'b0;
                        if (CD == 3'd0) begin
                            stateB_d = S_IDLE;
                            cntB_d   = 3'd0;
                        end else begin
                            stateB_d = S_COOL;
                            cntB_d   = CD;
                        end
                    end
                end
                S_COOL: begin
                    rejB_d = btnB;
                    if (bombTick) begin
                        if (cntB_q <= 3'd1) begin
                            stateB_d = S_IDLE;
                            cntB_d   = 3'd0;
                        end else begin
                            cntB_d = cntB_q - 3'd1;
                        end
                    end
                end
                default: begin
                    stateB_d  = S_IDLE;
                    cntB_d    = 3'd0;
                    bombB_v_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateA_q  <= S_IDLE;
            stateB_q  <= S_IDLE;
            cntA_q    <= 3'd0;
            cntB_q    <= 3'd0;
            bombA_x_q <= 4'd0;
            bombA_y_q <= 4'd0;
            bombB_x_q <= 4'd0;
            bombB_y_q <= 4'd0;
            bombA_v_q <= 1'b0;
            bombB_v_q <= 1'b0;
            rejA_q    <= 1'b0;
            rejB_q    <= 1'b0;
        end else begin
            stateA_q  <= stateA_d;
            stateB_q  <= stateB_d;
            cntA_q    <= cntA_d;
            cntB_q    <= cntB_d;
            bombA_x_q <= bombA_x_d;
            bombA_y_q <= bombA_y_d;
            bombB_x_q <= bombB_x_d;
            bombB_y_q <= bombB_y_d;
            bombA_v_q <= bombA_v_d;
            bombB_v_q <= bombB_v_d;
            rejA_q    <= rejA_d;
            rejB_q    <= rejB_d;
        end
    end

    assign bombA_x = bombA_x_q;
    assign bombA_y = bombA_y_q;
    assign bombB_x = bombB_x_q;
    assign bombB_y = bombB_y_q;
    assign bombA_v = bombA_v_q;
    assign bombB_v = bombB_v_q;
    assign rejA    = rejA_q;
    assign rejB    = rejB_q;
    assign busyA   = (stateA_q != S_IDLE);
    assign busyB   = (stateB_q != S_IDLE);

endmodule

// File: tb/tb_bomb_sched.sv
// Directed scoreboard bench for bomb_sched: default cooldown instance plus a zero-cooldown instance.
module tb_bomb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        bombTick, btnA, btnB;
    logic [3:0]  pAx, pAy, pBx, pBy;
    logic [99:0] m0, m1;
    logic [1:0]  gs;

    logic [3:0]  d_ax, d_ay, d_bx, d_by, z_ax, z_ay, z_bx, z_by;
    logic        d_av, d_bv, d_ra, d_rb, d_ba, d_bb;
    logic        z_av, z_bv, z_ra, z_rb, z_ba, z_bb;

    always #5 clk = ~clk;

    bomb_sched u_dut (
        .clk(clk), .rst(rst), .bombTick(bombTick), .btnA(btnA), .btnB(btnB),
        .playerAx(pAx), .playerAy(pAy), .playerBx(pBx), .playerBy(pBy),
        .i_curBombMap_0(m0), .i_curBombMap_1(m1), .game_state(gs),
        .bombA_x(d_ax), .bombA_y(d_ay), .bombB_x(d_bx), .bombB_y(d_by),
        .bombA_v(d_av), .bombB_v(d_bv), .rejA(d_ra), .rejB(d_rb),
        .busyA(d_ba), .busyB(d_bb)
    );

    bomb_sched #(.COOLDOWN_TICKS(0)) u_c0 (
        .clk(clk), .rst(rst), .bombTick(bombTick), .btnA(btnA), .btnB(btnB),
        .playerAx(pAx), .playerAy(pAy), .playerBx(pBx), .playerBy(pBy),
        .i_curBombMap_0(m0), .i_curBombMap_1(m1), .game_state(gs),
        .bombA_x(z_ax), .bombA_y(z_ay), .bombB_x(z_bx), .bombB_y(z_by),
        .bombA_v(z_av), .bombB_v(z_bv), .rejA(z_ra), .rejB(z_rb),
        .busyA(z_ba), .busyB(z_bb)
    );

    logic [21:0] obs_d, obs_z;
    assign obs_d = {d_av, d_ax, d_ay, d_ra, d_ba, d_bv, d_bx, d_by, d_rb, d_bb};
    assign obs_z = {z_av, z_ax, z_ay, z_ra, z_ba, z_bv, z_bx, z_by, z_rb, z_bb};

    typedef struct {
        logic [21:0] val;
        bit          sel;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [21:0] pk(
        input logic av, input logic [3:0] ax, input logic [3:0] ay, input logic ar, input logic ab,
        input logic bv, input logic [3:0] bx, input logic [3:0] by, input logic br, input logic bb
    );
        return {av, ax, ay, ar, ab, bv, bx, by, br, bb};
    endfunction

    task automatic compare_head();
        exp_t        e;
        logic [21:0] o;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e = sbq.pop_front();
            o = e.sel ? obs_z : obs_d;
            assert (o === e.val) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic cyc(input string tag, input bit sel, input logic [21:0] e);
        sbq.push_back('{val: e, sel: sel, tag: tag});
        @(posedge clk);
        #1;
        compare_head();
        btnA     = 1'b0;
        btnB     = 1'b0;
        bombTick = 1'b0;
    endtask

    task automatic now(input string tag, input bit sel, input logic [21:0] e);
        sbq.push_back('{val: e, sel: sel, tag: tag});
        #1;
        compare_head();
    endtask

    logic [3:0] bl;

    initial begin
`ifdef BOMB_RR_EN
        bl = 4'd5;
`else
        bl = 4'd0;
`endif
        rst = 1'b1; bombTick = 1'b0; btnA = 1'b0; btnB = 1'b0;
        pAx = 4'd3; pAy = 4'd4; pBx = 4'd0; pBy = 4'd0;
        m0 = '0; m1 = '0; gs = 2'd0;
        #2 rst = 1'b0;
        now("reset_d", 1'b0, 22'd0);
        now("reset_c0", 1'b1, 22'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic arm, tick, three cooldown ticks.
        btnA = 1'b1;     cyc("arm", 1'b0, pk(1,3,4,0,1, 0,0,0,0,0));
        cyc("armed_hold", 1'b0, pk(1,3,4,0,1, 0,0,0,0,0));
        bombTick = 1'b1; cyc("tick_cool", 1'b0, pk(0,3,4,0,1, 0,0,0,0,0));
        cyc("cool_hold", 1'b0, pk(0,3,4,0,1, 0,0,0,0,0));
        bombTick = 1'b1; cyc("cool2", 1'b0, pk(0,3,4,0,1, 0,0,0,0,0));
        bombTick = 1'b1; cyc("cool1", 1'b0, pk(0,3,4,0,1, 0,0,0,0,0));
        bombTick = 1'b1; cyc("cool_done", 1'b0, pk(0,3,4,0,0, 0,0,0,0,0));

        // Occupied cell and bounds.
        m1[34] = 1'b1; btnA = 1'b1;
        cyc("map_rej", 1'b0, pk(0,3,4,1,0, 0,0,0,0,0));
        cyc("rej_one", 1'b0, pk(0,3,4,0,0, 0,0,0,0,0));
        m1 = '0;
        pAx = 4'd10; pAy = 4'd2; btnA = 1'b1;
        cyc("oob_rej", 1'b0, pk(0,3,4,1,0, 0,0,0,0,0));
        pAx = 4'd9; pAy = 4'd9; btnA = 1'b1;
        cyc("edge99", 1'b0, pk(1,9,9,0,1, 0,0,0,0,0));
        gs = 2'd1; cyc("go_clear", 1'b0, pk(0,9,9,0,0, 0,0,0,0,0));
        gs = 2'd0;

        // Press while armed; other player's armed cell.
        pAx = 4'd3; pAy = 4'd4; btnA = 1'b1;
        cyc("arm2", 1'b0, pk(1,3,4,0,1, 0,0,0,0,0));
        btnA = 1'b1; cyc("armed_press", 1'b0, pk(1,3,4,1,1, 0,0,0,0,0));
        pBx = 4'd3; pBy = 4'd4; btnB = 1'b1;
        cyc("b_vs_armed", 1'b0, pk(1,3,4,0,1, 0,0,0,1,0));

        // Game over.
        gs = 2'd2; cyc("gameover", 1'b0, pk(0,3,4,0,0, 0,0,0,0,0));
        btnA = 1'b1; btnB = 1'b1;
        cyc("go_btn", 1'b0, pk(0,3,4,0,0, 0,0,0,0,0));
        gs = 2'd0;

        // Same-cell ties.
        pAx = 4'd5; pAy = 4'd5; pBx = 4'd5; pBy = 4'd5;
        btnA = 1'b1; btnB = 1'b1;
        cyc("tie1", 1'b0, pk(1,5,5,0,1, 0,0,0,1,0));
        gs = 2'd1; cyc("tie1_clr", 1'b0, pk(0,5,5,0,0, 0,0,0,0,0));
        gs = 2'd0;
        btnA = 1'b1; btnB = 1'b1;
`ifdef BOMB_RR_EN
        cyc("tie2", 1'b0, pk(0,5,5,1,0, 1,5,5,0,1));
`else
        cyc("tie2", 1'b0, pk(1,5,5,0,1, 0,0,0,1,0));
`endif
        gs = 2'd1; cyc("tie2_clr", 1'b0, pk(0,5,5,0,0, 0,bl,bl,0,0));
        gs = 2'd0;

        // Press coincident with a tick.
        pAx = 4'd2; pAy = 4'd7; pBx = 4'd0; pBy = 4'd0;
        btnA = 1'b1; bombTick = 1'b1;
        cyc("arm_on_tick", 1'b0, pk(1,2,7,0,1, 0,bl,bl,0,0));
        cyc("survive_tick", 1'b0, pk(1,2,7,0,1, 0,bl,bl,0,0));
        bombTick = 1'b1; cyc("tick_after", 1'b0, pk(0,2,7,0,1, 0,bl,bl,0,0));
        gs = 2'd1; cyc("clr3", 1'b0, pk(0,2,7,0,0, 0,bl,bl,0,0));
        gs = 2'd0;

        // Zero-cooldown instance: async reset mid-ARMED, re-arm, immediate IDLE.
        rst = 1'b0;
        now("rst_d", 1'b0, 22'd0);
        now("rst_c0", 1'b1, 22'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        pAx = 4'd3; pAy = 4'd4; btnA = 1'b1;
        cyc("c0_arm", 1'b1, pk(1,3,4,0,1, 0,0,0,0,0));
        rst = 1'b0;
        now("c0_rst_armed", 1'b1, 22'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        btnA = 1'b1;     cyc("c0_rearm", 1'b1, pk(1,3,4,0,1, 0,0,0,0,0));
        bombTick = 1'b1; cyc("c0_tick_idle", 1'b1, pk(0,3,4,0,0, 0,0,0,0,0));
        btnA = 1'b1;     cyc("c0_again", 1'b1, pk(1,3,4,0,1, 0,0,0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
